// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//
// Resolves conditional branches at the end of Execute and registers the
// outcome into Memory. The M-stage register feeds the direction predictor
// update port (branchM / actual_takeM / pcM). A mispredict raises a
// valid/ready redirect request toward fetch, and the request is held until
// fetch accepts it. Saturating counters record branches and mispredicts.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   stallM, flushM      E->M register hold / bubble insert (flush wins)
//   branchE, branchL_E  E-stage conditional branch, branch-likely variant
//   pred_takeE          predicted direction carried down from D
//   condE               000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz,
//                       101 bgez, 11x never taken
//   rs_valE, rt_valE    forwarded operands
//   pcE, immE           branch PC, sign-extended word offset (unshifted)
//   redirect_ready      fetch accepts the redirect this cycle
//   branchM, actual_takeM, pcM   predictor update port
//   mispredM, annul_slotM        fresh-only M-stage event flags
//   redirect_valid, redirect_pc  redirect request to fetch
//   redirect_err        sticky: mispredict seen while a redirect was pending
//   branch_cnt, mispred_cnt      saturating performance counters

module branch_resolve_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallM,
    input  logic             flushM,
    input  logic             branchE,
    input  logic             branchL_E,
    input  logic             pred_takeE,
    input  logic [2:0]       condE,
    input  logic [31:0]      rs_valE,
    input  logic [31:0]      rt_valE,
    input  logic [31:0]      pcE,
    input  logic [31:0]      immE,
    input  logic             redirect_ready,
    output logic             branchM,
    output logic             actual_takeM,
    output logic [31:0]      pcM,
    output logic             mispredM,
    output logic             annul_slotM,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             redirect_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // E stage: condition evaluation and redirect address
    // ------------------------------------------------------------------
    logic        cond_met;
    logic        take_e;
    logic        rs_zero;
    logic        rs_neg;
    logic [31:0] target_e;
    logic [31:0] fall_e;
    logic [31:0] redir_e;

    assign rs_zero = (rs_valE == 32'd0);
    assign rs_neg  = rs_valE[31];

    always_comb begin
        cond_met = 1'b0;
        case (condE)
            3'b000:  cond_met = (rs_valE == rt_valE);
            3'b001:  cond_met = (rs_valE != rt_valE);
            3'b010:  cond_met = rs_neg | rs_zero;     // blez
            3'b011:  cond_met = ~rs_neg & ~rs_zero;   // bgtz
            3'b100:  cond_met = rs_neg;               // bltz
            3'b101:  cond_met = ~rs_neg;              // bgez
            default: cond_met = 1'b0;
        endcase
    end

    assign take_e   = branchE & cond_met;
    assign target_e = pcE + 32'd4 + (immE << 2);
    // Fall-through skips the delay slot, which has already been fetched.
    assign fall_e   = pcE + 32'd8;
    assign redir_e  = take_e ? target_e : fall_e;

    // ------------------------------------------------------------------
    // E->M register
    // ------------------------------------------------------------------
    logic        vld_m;
    logic        take_m;
    logic        pred_m;
    logic        likely_m;
    logic [31:0] pc_m;
    logic [31:0] redir_addr_m;
    // Set on every load, cleared while held, so a stalled entry raises its
    // mispredict / annul / count events exactly once.
    logic        fresh_m;

    always_ff @(posedge clk) begin
        if (rst || flushM) begin
            vld_m        <= 1'b0;
            take_m       <= 1'b0;
            pred_m       <= 1'b0;
            likely_m     <= 1'b0;
            pc_m         <= 32'd0;
            redir_addr_m <= 32'd0;
            fresh_m      <= 1'b0;
        end else if (!stallM) begin
            vld_m        <= branchE;
            take_m       <= take_e;
            pred_m       <= pred_takeE;
            likely_m     <= branchL_E;
            pc_m         <= pcE;
            redir_addr_m <= redir_e;
            fresh_m      <= 1'b1;
        end else begin
            fresh_m      <= 1'b0;
        end
    end

    logic fresh_br;
    assign fresh_br     = fresh_m & vld_m;

    assign branchM      = vld_m;
    assign actual_takeM = take_m;
    assign pcM          = pc_m;
    assign mispredM     = fresh_br & (take_m ^ pred_m);
    assign annul_slotM  = fresh_br & likely_m & ~take_m;

    // ------------------------------------------------------------------
    // Redirect handshake
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pend_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pend_pc      <= 32'd0;
            redirect_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && mispredM && !redirect_ready)
                pend_pc <= redir_addr_m;
            // A second mispredict while one is outstanding cannot be
            // queued; flag it and keep the original request intact.
            if (state == PEND && mispredM)
                redirect_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        redirect_valid = 1'b0;
        redirect_pc    = redir_addr_m;
        case (state)
            IDLE: begin
                redirect_valid = mispredM;
                redirect_pc    = redir_addr_m;
                if (mispredM && !redirect_ready)
                    state_nxt = PEND;
            end
            PEND: begin
                redirect_valid = 1'b1;
                redirect_pc    = pend_pc;
                if (redirect_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (fresh_br && !(&branch_cnt))
                branch_cnt <= branch_cnt + CNT_ONE;
            if (mispredM && !(&mispred_cnt))
                mispred_cnt <= mispred_cnt + CNT_ONE;
        end
    end

endmodule
